// File: rtl/synaptic_weight_accumulator.sv
//------------------------------------------------------------------------------
// synaptic_weight_accumulator
//
// Purpose:
//   Producer side of the neuron unit's weight-sum interface. A handshaked
//   stream of per-spike synaptic weights is accumulated into separate
//   excitatory and inhibitory sums for one timestep. The beat flagged InLast
//   closes the step. The totals are then published through a single-entry
//   output buffer (SumValid/SumAccept). Accumulation of the next step carries
//   on while the published step waits to be consumed.
//
// Configuration macro:
//   WTSUM_SATURATE_EN - when defined, signed overflow clamps to the DATA_WIDTH
//                       signed max/min and sets a sticky per-step flag.
//                       When undefined, sums wrap and ExSat/InSat read 0.
//
// Ports:
//   Clock, Reset         rising-edge clock, synchronous active-high reset
//   InValid/InReady      input beat handshake
//   InWeight             signed fixed-point weight (DATA_WIDTH bits)
//   InInhibitory         0 = excitatory sum, 1 = inhibitory sum
//   InLast               beat closes the current timestep
//   ExWeightSum          published excitatory sum
//   InWeightSum          published inhibitory sum
//   SpikeCount           beats in the published step, Last beat included
//   SumValid/SumAccept   output buffer handshake
//   ExSat, InSat         sticky saturation flags of the published step
//------------------------------------------------------------------------------
module synaptic_weight_accumulator #(
   parameter int INTEGER_WIDTH   = 32,
   parameter int DATA_WIDTH_FRAC = 32,
   parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
   parameter int COUNT_WIDTH     = 16
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic                   InValid,
   output logic                   InReady,
   input  logic [DATA_WIDTH-1:0]  InWeight,
   input  logic                   InInhibitory,
   input  logic                   InLast,
   output logic [DATA_WIDTH-1:0]  ExWeightSum,
   output logic [DATA_WIDTH-1:0]  InWeightSum,
   output logic [COUNT_WIDTH-1:0] SpikeCount,
   output logic                   SumValid,
   input  logic                   SumAccept,
   output logic                   ExSat,
   output logic                   InSat
);

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                 state_r;
   state_t                 state_next_s;

   logic [DATA_WIDTH-1:0]  acc_ex_r;
   logic [DATA_WIDTH-1:0]  acc_in_r;
   logic [COUNT_WIDTH-1:0] acc_cnt_r;

   logic                   accept_s;
   logic                   last_acc_s;
   logic [DATA_WIDTH-1:0]  ex_sum_s;
   logic [DATA_WIDTH-1:0]  in_sum_s;
   logic [DATA_WIDTH-1:0]  ex_val_s;
   logic [DATA_WIDTH-1:0]  in_val_s;
   logic [DATA_WIDTH-1:0]  acc_ex_next_s;
   logic [DATA_WIDTH-1:0]  acc_in_next_s;
   logic [COUNT_WIDTH-1:0] acc_cnt_next_s;

`ifdef WTSUM_SATURATE_EN
   logic                   acc_ex_sat_r;
   logic                   acc_in_sat_r;
   logic                   ex_ovf_s;
   logic                   in_ovf_s;
   logic                   acc_ex_sat_next_s;
   logic                   acc_in_sat_next_s;

   // Sign rule: operands of equal sign producing a result of the other sign.
   function automatic logic add_ovf(input logic [DATA_WIDTH-1:0] a,
                                    input logic [DATA_WIDTH-1:0] b,
                                    input logic [DATA_WIDTH-1:0] s);
      return (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (s[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
   endfunction

   // Clamp value for an overflow; direction follows the (shared) operand sign.
   function automatic logic [DATA_WIDTH-1:0] sat_bound(input logic neg);
      return neg ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
   endfunction
`endif

   // Handshake: only a Last beat stalls, and only while the buffer is full and not draining.
   always_comb begin
      InReady    = !(InValid && InLast && SumValid && !SumAccept);
      accept_s   = InValid && InReady;
      last_acc_s = accept_s && InLast;
   end

   // Accumulator datapath: add the accepted beat into the selected sum and count it.
   always_comb begin
      ex_sum_s = acc_ex_r + InWeight;
      in_sum_s = acc_in_r + InWeight;
`ifdef WTSUM_SATURATE_EN
      ex_ovf_s = add_ovf(acc_ex_r, InWeight, ex_sum_s);
      in_ovf_s = add_ovf(acc_in_r, InWeight, in_sum_s);
      ex_val_s = ex_ovf_s ? sat_bound(acc_ex_r[DATA_WIDTH-1]) : ex_sum_s;
      in_val_s = in_ovf_s ? sat_bound(acc_in_r[DATA_WIDTH-1]) : in_sum_s;
      acc_ex_sat_next_s = acc_ex_sat_r | (accept_s && !InInhibitory && ex_ovf_s);
      acc_in_sat_next_s = acc_in_sat_r | (accept_s &&  InInhibitory && in_ovf_s);
`else
      ex_val_s = ex_sum_s;
      in_val_s = in_sum_s;
`endif
      acc_ex_next_s = (accept_s && !InInhibitory) ? ex_val_s : acc_ex_r;
      acc_in_next_s = (accept_s &&  InInhibitory) ? in_val_s : acc_in_r;
      if (accept_s && (acc_cnt_r != {COUNT_WIDTH{1'b1}})) begin
         acc_cnt_next_s = acc_cnt_r + CNT_ONE;
      end else begin
         acc_cnt_next_s = acc_cnt_r;
      end
   end

   // Accumulators: clear when a step is closed, otherwise follow the datapath.
   always_ff @(posedge Clock) begin
      if (Reset || last_acc_s) begin
         acc_ex_r     <= {DATA_WIDTH{1'b0}};
         acc_in_r     <= {DATA_WIDTH{1'b0}};
         acc_cnt_r    <= {COUNT_WIDTH{1'b0}};
`ifdef WTSUM_SATURATE_EN
         acc_ex_sat_r <= 1'b0;
         acc_in_sat_r <= 1'b0;
`endif
      end else begin
         acc_ex_r     <= acc_ex_next_s;
         acc_in_r     <= acc_in_next_s;
         acc_cnt_r    <= acc_cnt_next_s;
`ifdef WTSUM_SATURATE_EN
         acc_ex_sat_r <= acc_ex_sat_next_s;
         acc_in_sat_r <= acc_in_sat_next_s;
`endif
      end
   end

   // Published outputs: reload on every closed step (including the Last beat itself), hold otherwise.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         ExWeightSum <= {DATA_WIDTH{1'b0}};
         InWeightSum <= {DATA_WIDTH{1'b0}};
         SpikeCount  <= {COUNT_WIDTH{1'b0}};
      end else if (last_acc_s) begin
         ExWeightSum <= acc_ex_next_s;
         InWeightSum <= acc_in_next_s;
         SpikeCount  <= acc_cnt_next_s;
      end else begin
         ExWeightSum <= ExWeightSum;
         InWeightSum <= InWeightSum;
         SpikeCount  <= SpikeCount;
      end
   end

`ifdef WTSUM_SATURATE_EN
   // Published saturation flags travel with the published sums.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         ExSat <= 1'b0;
         InSat <= 1'b0;
      end else if (last_acc_s) begin
         ExSat <= acc_ex_sat_next_s;
         InSat <= acc_in_sat_next_s;
      end else begin
         ExSat <= ExSat;
         InSat <= InSat;
      end
   end
`else
   // Wrapping arithmetic never saturates.
   assign ExSat = 1'b0;
   assign InSat = 1'b0;
`endif

   // Output buffer FSM: state register.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_r <= ST_EMPTY;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Output buffer FSM: a closed step fills the buffer even while it is being drained.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_EMPTY: begin
            if (last_acc_s) begin
               state_next_s = ST_FULL;
            end else begin
               state_next_s = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (last_acc_s) begin
               state_next_s = ST_FULL;
            end else if (SumAccept) begin
               state_next_s = ST_EMPTY;
            end else begin
               state_next_s = ST_FULL;
            end
         end
         default: begin
            state_next_s = ST_EMPTY;
         end
      endcase
   end

   // Output buffer FSM: state decode.
   always_comb begin
      SumValid = 1'b0;
      case (state_r)
         ST_EMPTY: SumValid = 1'b0;
         ST_FULL:  SumValid = 1'b1;
         default:  SumValid = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_synaptic_weight_accumulator.sv
//------------------------------------------------------------------------------
// tb_synaptic_weight_accumulator
//
// Directed bench. Expected published steps are pushed to a scoreboard queue
// when their Last beat is driven. They are popped and compared when the DUT
// publishes. Inputs change on the falling edge. Outputs are sampled 1 time
// unit after the rising edge.
//------------------------------------------------------------------------------
module tb_synaptic_weight_accumulator;

   localparam int IW = 32;
   localparam int FW = 32;
   localparam int DW = IW + FW;
   localparam int CW = 16;

   localparam logic [DW-1:0] W_0P25 = 64'h0000_0000_4000_0000;
   localparam logic [DW-1:0] W_1P0  = 64'h0000_0001_0000_0000;
   localparam logic [DW-1:0] W_1P5  = 64'h0000_0001_8000_0000;
   localparam logic [DW-1:0] W_2P0  = 64'h0000_0002_0000_0000;
   localparam logic [DW-1:0] W_3P0  = 64'h0000_0003_0000_0000;
   localparam logic [DW-1:0] W_3P5  = 64'h0000_0003_8000_0000;
   localparam logic [DW-1:0] W_5P0  = 64'h0000_0005_0000_0000;
   localparam logic [DW-1:0] W_M2P0 = 64'hFFFF_FFFE_0000_0000;
   localparam logic [DW-1:0] W_M0P5 = 64'hFFFF_FFFF_8000_0000;
   localparam logic [DW-1:0] W_BIG  = 64'h7FFF_FFFF_0000_0000;
   localparam logic [DW-1:0] W_ZERO = 64'h0;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          InValid;
   logic          InReady;
   logic [DW-1:0] InWeight;
   logic          InInhibitory;
   logic          InLast;
   logic [DW-1:0] ExWeightSum;
   logic [DW-1:0] InWeightSum;
   logic [CW-1:0] SpikeCount;
   logic          SumValid;
   logic          SumAccept;
   logic          ExSat;
   logic          InSat;

   typedef struct packed {
      logic [DW-1:0] ex;
      logic [DW-1:0] inh;
      logic [CW-1:0] cnt;
      logic          exsat;
      logic          insat;
   } pub_t;

   pub_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   synaptic_weight_accumulator #(
      .INTEGER_WIDTH   (IW),
      .DATA_WIDTH_FRAC (FW),
      .DATA_WIDTH      (DW),
      .COUNT_WIDTH     (CW)
   ) dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .InValid      (InValid),
      .InReady      (InReady),
      .InWeight     (InWeight),
      .InInhibitory (InInhibitory),
      .InLast       (InLast),
      .ExWeightSum  (ExWeightSum),
      .InWeightSum  (InWeightSum),
      .SpikeCount   (SpikeCount),
      .SumValid     (SumValid),
      .SumAccept    (SumAccept),
      .ExSat        (ExSat),
      .InSat        (InSat)
   );

   always #5 Clock = ~Clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One beat: drive on the falling edge, require InReady, clock it in, release.
   task automatic beat(input logic [DW-1:0] w, input logic inh, input logic last,
                       input logic acc, input string tag);
      @(negedge Clock);
      InValid = 1'b1; InWeight = w; InInhibitory = inh; InLast = last; SumAccept = acc;
      #1;
      chk({tag, ".ready"}, {63'd0, InReady}, 64'd1);
      @(posedge Clock);
      #1;
      InValid = 1'b0; InLast = 1'b0; InInhibitory = 1'b0; InWeight = W_ZERO; SumAccept = 1'b0;
   endtask

   task automatic expect_pub(input logic [DW-1:0] ex, input logic [DW-1:0] inh,
                             input logic [CW-1:0] cnt, input logic exsat, input logic insat);
      pub_t p;
      p.ex = ex; p.inh = inh; p.cnt = cnt; p.exsat = exsat; p.insat = insat;
      sb_q.push_back(p);
   endtask

   task automatic check_pub(input string tag);
      pub_t p;
      chk({tag, ".sb_nonempty"}, {63'd0, (sb_q.size() != 0)}, 64'd1);
      if (sb_q.size() != 0) begin
         p = sb_q.pop_front();
         chk({tag, ".valid"}, {63'd0, SumValid}, 64'd1);
         chk({tag, ".ex"},    ExWeightSum, p.ex);
         chk({tag, ".in"},    InWeightSum, p.inh);
         chk({tag, ".cnt"},   {48'd0, SpikeCount}, {48'd0, p.cnt});
         chk({tag, ".exsat"}, {63'd0, ExSat}, {63'd0, p.exsat});
         chk({tag, ".insat"}, {63'd0, InSat}, {63'd0, p.insat});
      end else begin
         chk({tag, ".sb_empty_state"}, {63'd0, SumValid}, 64'd1);
      end
   endtask

   // Pulse SumAccept for one cycle with no input beat.
   task automatic drain;
      @(negedge Clock);
      SumAccept = 1'b1;
      @(posedge Clock);
      #1;
      SumAccept = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; InValid = 1'b0; InWeight = W_ZERO; InInhibitory = 1'b0;
      InLast = 1'b0; SumAccept = 1'b0;

      // Reset state
      @(posedge Clock);
      @(posedge Clock);
      #1;
      chk("rst.valid", {63'd0, SumValid}, 64'd0);
      chk("rst.ex",    ExWeightSum, 64'd0);
      chk("rst.in",    InWeightSum, 64'd0);
      chk("rst.cnt",   {48'd0, SpikeCount}, 64'd0);
      chk("rst.ready", {63'd0, InReady}, 64'd1);
      @(negedge Clock);
      Reset = 1'b0;

      // Basic step: ex 1.5, ex 2.0, in 0.25 Last
      beat(W_1P5, 1'b0, 1'b0, 1'b0, "basic.b0");
      chk("basic.notyet", {63'd0, SumValid}, 64'd0);
      beat(W_2P0, 1'b0, 1'b0, 1'b0, "basic.b1");
      expect_pub(W_3P5, W_0P25, 16'd3, 1'b0, 1'b0);
      beat(W_0P25, 1'b1, 1'b1, 1'b0, "basic.last");
      check_pub("basic");

      // Accept/drain: valid drops, sums hold
      drain();
      chk("drain.valid", {63'd0, SumValid}, 64'd0);
      chk("drain.ex",    ExWeightSum, W_3P5);
      chk("drain.in",    InWeightSum, W_0P25);
      chk("drain.cnt",   {48'd0, SpikeCount}, 64'd3);

      // Empty step
      expect_pub(W_ZERO, W_ZERO, 16'd1, 1'b0, 1'b0);
      beat(W_ZERO, 1'b0, 1'b1, 1'b0, "empty.last");
      check_pub("empty");

      // Backpressure: empty step left unconsumed, stream ex 1.0 x3
      beat(W_1P0, 1'b0, 1'b0, 1'b0, "bp.b0");
      beat(W_1P0, 1'b0, 1'b0, 1'b0, "bp.b1");
      @(negedge Clock);
      InValid = 1'b1; InWeight = W_1P0; InInhibitory = 1'b0; InLast = 1'b1; SumAccept = 1'b0;
      #1;
      chk("bp.stall_ready", {63'd0, InReady}, 64'd0);
      @(posedge Clock);
      #1;
      chk("bp.stall_valid", {63'd0, SumValid}, 64'd1);
      chk("bp.stall_ex",    ExWeightSum, W_ZERO);
      chk("bp.stall_cnt",   {48'd0, SpikeCount}, 64'd1);
      @(negedge Clock);
      SumAccept = 1'b1;
      #1;
      chk("bp.accept_ready", {63'd0, InReady}, 64'd1);
      expect_pub(W_3P0, W_ZERO, 16'd3, 1'b0, 1'b0);
      @(posedge Clock);
      #1;
      InValid = 1'b0; InLast = 1'b0; InWeight = W_ZERO; SumAccept = 1'b0;
      check_pub("bp");

      // Throughput: SumAccept held, back-to-back single-beat steps
      expect_pub(W_M2P0, W_ZERO, 16'd1, 1'b0, 1'b0);
      beat(W_M2P0, 1'b0, 1'b1, 1'b1, "tput.s0");
      check_pub("tput0");
      expect_pub(W_ZERO, W_M0P5, 16'd1, 1'b0, 1'b0);
      beat(W_M0P5, 1'b1, 1'b1, 1'b1, "tput.s1");
      check_pub("tput1");
      drain();
      chk("tput.drain_valid", {63'd0, SumValid}, 64'd0);

      // Overflow: two large positive weights, then Last 0
      beat(W_BIG, 1'b0, 1'b0, 1'b0, "sat.b0");
      beat(W_BIG, 1'b0, 1'b0, 1'b0, "sat.b1");
`ifdef WTSUM_SATURATE_EN
      expect_pub(64'h7FFF_FFFF_FFFF_FFFF, W_ZERO, 16'd3, 1'b1, 1'b0);
`else
      expect_pub(64'hFFFF_FFFE_0000_0000, W_ZERO, 16'd3, 1'b0, 1'b0);
`endif
      beat(W_ZERO, 1'b0, 1'b1, 1'b0, "sat.last");
      check_pub("sat");

      // Reset mid-step: partial ex 5.0 discarded along with the pending step
      beat(W_5P0, 1'b0, 1'b0, 1'b0, "rmid.b0");
      @(negedge Clock);
      Reset = 1'b1;
      @(posedge Clock);
      #1;
      chk("rmid.valid", {63'd0, SumValid}, 64'd0);
      chk("rmid.ex",    ExWeightSum, 64'd0);
      chk("rmid.cnt",   {48'd0, SpikeCount}, 64'd0);
      @(negedge Clock);
      Reset = 1'b0;
      sb_q.delete();
      expect_pub(W_1P0, W_ZERO, 16'd1, 1'b0, 1'b0);
      beat(W_1P0, 1'b0, 1'b1, 1'b0, "rmid.last");
      check_pub("rmid");

      // Nothing left outstanding
      chk("sb.drained", sb_q.size(), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
